// File: rtl/alu_issue_wb_pkg.sv
// Shared constants and types for the ALU issue/writeback stage.
// Opcode/flag encodings must match the external ALU.
package alu_issue_wb_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b0111;

  localparam logic [3:0] FLG_CARRY = 4'b1000;
  localparam logic [3:0] FLG_NEG   = 4'b0100;
  localparam logic [3:0] FLG_ZERO  = 4'b0010;
  localparam logic [3:0] FLG_NONE  = 4'b0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } instr_t;

  // Opcodes with the top bit set are NOPs.
  function automatic logic op_writes_rd(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic op_writes_flags(input logic [3:0] op);
    return ~op[3] && (op != OP_MOV);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: one write port, two operand reads and a debug read.
// Reads are combinational; the issue stage samples them at the READ->EXEC edge.
module alu_regfile
  import alu_issue_wb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = regs_q[raddr1_i];
  assign rdata2_o   = regs_q[raddr2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around an external combinational ALU.
// state   | meaning
// IDLE    | ready for an instruction or an external register load
// READ    | operands read from the register file
// EXEC    | ALU inputs registered, ALU settling
// WB      | result written to rd and flags at the closing edge
module alu_issue_wb
  import alu_issue_wb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [15:0]       instr_i,
  output logic              instr_ready_o,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_data_i,
  output logic [3:0]        alu_opcode_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [3:0]        alu_flag_i,
  output logic [3:0]        flags_o,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [1:0]        state_q, state_d;
  instr_t            instr_q, instr_dec;
  logic [3:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic [3:0]        flag_q, flags_q;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              accept, ext_fire, wb_fire, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              instr_unused;

  assign instr_dec    = instr_t'(instr_i[15:3]);
  assign instr_unused = ^instr_i[2:0];

  // Reset also masks the handshake and writeback during the reset cycle.
  assign instr_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept        = instr_valid_i && instr_ready_o;
  assign ext_fire      = ext_we_i && (state_q == ST_IDLE) && !rst_i;
  assign wb_fire       = (state_q == ST_WB) && op_writes_rd(instr_q.op) && !rst_i;

  assign rf_we    = wb_fire || ext_fire;
  assign rf_waddr = wb_fire ? instr_q.rd : ext_addr_i;
  assign rf_wdata = wb_fire ? result_q   : ext_data_i;

  alu_regfile u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr1_i   (instr_q.rs1),
    .raddr2_i   (instr_q.rs2),
    .dbg_addr_i (dbg_addr_i),
    .rdata1_o   (rdata1),
    .rdata2_o   (rdata2),
    .dbg_data_o (dbg_data_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      flag_q       <= '0;
      flags_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr_dec;
      if (state_q == ST_READ) begin
        alu_opcode_q <= instr_q.op;
        alu_a_q      <= rdata1;
        alu_b_q      <= rdata2;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_out_i;
        flag_q   <= alu_flag_i;
      end
      if ((state_q == ST_WB) && op_writes_flags(instr_q.op)) flags_q <= flag_q;
    end
  end

  assign alu_opcode_o = alu_opcode_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign flags_o      = flags_q;
  assign wb_valid_o   = wb_fire;
  assign wb_addr_o    = instr_q.rd;
  assign wb_data_o    = result_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with a behavioural ALU attached to its ALU ports.
`timescale 1ns/1ps
module tb_alu_issue_wb;
  import alu_issue_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, instr_valid, ext_we, instr_ready, wb_valid;
  logic [15:0] instr, ext_data, alu_out, alu_a, alu_b, wb_data, dbg_data;
  logic [2:0]  ext_addr, wb_addr, dbg_addr;
  logic [3:0]  alu_opcode, alu_flag, flags;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(instr_ready), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
    .ext_data_i(ext_data), .alu_opcode_o(alu_opcode), .alu_a_o(alu_a),
    .alu_b_o(alu_b), .alu_out_i(alu_out), .alu_flag_i(alu_flag), .flags_o(flags),
    .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wb_exp_t;

  wb_exp_t     sb[$];
  logic [15:0] mreg [8];
  logic [3:0]  mflags;
  int          n_vec = 0, n_err = 0, cyc = 0, n_wb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] f);
    logic [16:0] w;
    case (op)
      OP_ADD:  w = {1'b0, a} + {1'b0, b};
      OP_SUB:  w = {1'b0, a} - {1'b0, b};
      OP_AND:  w = {1'b0, a & b};
      OP_OR:   w = {1'b0, a | b};
      OP_XOR:  w = {1'b0, a ^ b};
      OP_NOT:  w = {1'b0, ~a};
      OP_SHL:  w = {a, 1'b0};
      default: w = {1'b0, a};
    endcase
    r = w[15:0];
    f = w[16] ? FLG_CARRY : r[15] ? FLG_NEG : (r == 16'h0) ? FLG_ZERO : FLG_NONE;
  endfunction

  always_comb begin
    alu_f(alu_opcode, alu_a, alu_b, alu_out, alu_flag);
  end

  // Writeback monitor: every WB cycle must match the oldest expected write, at the expected cycle.
  always @(negedge clk) begin : mon
    wb_exp_t e;
    if (wb_valid === 1'b1) begin
      n_wb++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no writeback", wb_addr, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_addr !== e.addr || wb_data !== e.data || cyc !== e.cyc) begin
          n_err++;
          $display("FAIL wb_scoreboard: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                   wb_addr, wb_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    mflags = 4'h0;
    sb.delete();
  endtask

  task automatic ext_load(input logic [2:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    @(posedge clk); #1;
    ext_we = 1'b0;
    mreg[a] = d;
  endtask

  // Returns #1 after the accepting edge; pushes the expected writeback.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit hold, output int acc);
    logic [15:0] r;
    logic [3:0]  f;
    wb_exp_t     e;
    int          n;
    instr = {op, rd, rs1, rs2, 3'b101};
    instr_valid = 1'b1;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: instr_ready=%b after %0d cycles, expected 1", instr_ready, n);
      instr_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) instr_valid = 1'b0;
    ext_we = 1'b0;
    alu_f(op, mreg[rs1], mreg[rs2], r, f);
    if (!op[3]) begin
      e.addr = rd; e.data = r; e.cyc = acc + 2;
      sb.push_back(e);
      mreg[rd] = r;
      if (op != OP_MOV) mflags = f;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int acc;
    rst = 1'b1; instr_valid = 1'b0; ext_we = 1'b0; instr = '0;
    ext_addr = '0; ext_data = '0; dbg_addr = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    ext_load(3'd3, 16'hBEEF);
    issue(OP_ADD, 3'd4, 3'd3, 3'd3, 1'b0, acc);
    settle();
    n_vec++;
    if (flags !== FLG_CARRY) begin
      n_err++; $display("FAIL pre_reset_flags: got %b expected %b", flags, FLG_CARRY);
    end
    issue(OP_ADD, 3'd5, 3'd4, 3'd3, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (instr_ready !== 1'b0) begin
      n_err++; $display("FAIL ready_in_reset: got %b expected 0", instr_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    #1;
    n_vec++;
    if (instr_ready !== 1'b1 || flags !== 4'h0 || alu_opcode !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
      n_err++;
      $display("FAIL post_reset_state: got ready=%b flags=%b op=%h a=%h b=%h expected 1 0000 0 0000 0000",
               instr_ready, flags, alu_opcode, alu_a, alu_b);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      @(negedge clk);
      n_vec++;
      if (dbg_data !== 16'h0) begin
        n_err++; $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_data);
      end
    end
  endtask

  task automatic test_add_carry();
    int acc, w0;
    ext_load(3'd1, 16'hFFFF);
    ext_load(3'd2, 16'h0001);
    ext_load(3'd3, 16'h5555);
    w0 = n_wb;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, acc);
    settle();
    dbg_addr = 3'd3; #1;
    n_vec++;
    if (dbg_data !== 16'h0000 || flags !== 4'b1000 || n_wb - w0 != 1) begin
      n_err++;
      $display("FAIL add_carry: got r3=%h flags=%b wb_cycles=%0d expected 0000 1000 1", dbg_data, flags, n_wb - w0);
    end
  endtask

  task automatic test_sub_mov();
    int acc;
    ext_load(3'd4, 16'h1234);
    ext_load(3'd5, 16'h1234);
    issue(OP_SUB, 3'd6, 3'd4, 3'd5, 1'b0, acc);
    settle();
    dbg_addr = 3'd6; #1;
    n_vec++;
    if (dbg_data !== 16'h0000 || flags !== 4'b0010) begin
      n_err++; $display("FAIL sub_zero: got r6=%h flags=%b expected 0000 0010", dbg_data, flags);
    end
    issue(OP_MOV, 3'd7, 3'd4, 3'd1, 1'b0, acc);
    settle();
    dbg_addr = 3'd7; #1;
    n_vec++;
    if (dbg_data !== 16'h1234 || flags !== 4'b0010) begin
      n_err++; $display("FAIL mov_keep_flags: got r7=%h flags=%b expected 1234 0010", dbg_data, flags);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    logic [3:0] ready_trace;
    ext_load(3'd1, 16'h00F0);
    ext_load(3'd2, 16'h0F0F);
    issue(OP_XOR, 3'd3, 3'd1, 3'd2, 1'b1, a0);
    issue(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b1, a1);
    issue(OP_AND, 3'd5, 3'd1, 3'd2, 1'b0, a2);
    ready_trace[0] = instr_ready;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      ready_trace[i] = instr_ready;
    end
    n_vec++;
    if (a1 - a0 != 4 || a2 - a1 != 4) begin
      n_err++; $display("FAIL accept_spacing: got %0d,%0d expected 4,4", a1 - a0, a2 - a1);
    end
    n_vec++;
    if (ready_trace !== 4'b1000) begin
      n_err++; $display("FAIL ready_trace: got %b (IDLE,WB,EXEC,READ) expected 1000", ready_trace);
    end
    for (int r = 3; r < 6; r++) begin
      dbg_addr = r[2:0]; #1;
      n_vec++;
      if (dbg_data !== mreg[r]) begin
        n_err++; $display("FAIL b2b_reg%0d: got %h expected %h", r, dbg_data, mreg[r]);
      end
    end
    n_vec++;
    if (flags !== mflags) begin
      n_err++; $display("FAIL b2b_flags: got %b expected %b", flags, mflags);
    end
  endtask

  task automatic test_reset_exec();
    int acc, w0;
    ext_load(3'd1, 16'h0001);
    ext_load(3'd2, 16'h0002);
    w0 = n_wb;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    repeat (4) @(posedge clk); #1;
    dbg_addr = 3'd3; #1;
    n_vec++;
    if (dbg_data !== 16'h0 || n_wb != w0 || instr_ready !== 1'b1 || flags !== 4'h0) begin
      n_err++;
      $display("FAIL reset_in_exec: got r3=%h wb_cycles=%0d ready=%b flags=%b expected 0000 0 1 0000",
               dbg_data, n_wb - w0, instr_ready, flags);
    end
  endtask

  task automatic test_nop_same_edge();
    int acc, w0;
    ext_load(3'd1, 16'h1111);
    ext_load(3'd2, 16'h2222);
    issue(OP_SUB, 3'd3, 3'd1, 3'd1, 1'b0, acc);
    settle();
    ext_load(3'd3, 16'h3333);
    w0 = n_wb;
    issue(4'b1010, 3'd3, 3'd1, 3'd2, 1'b0, acc);
    @(posedge clk); #1;
    n_vec++;
    if (alu_opcode !== 4'b1010 || alu_a !== 16'h1111 || alu_b !== 16'h2222) begin
      n_err++; $display("FAIL nop_forward: got op=%b a=%h b=%h expected 1010 1111 2222", alu_opcode, alu_a, alu_b);
    end
    repeat (2) @(posedge clk); #1;
    dbg_addr = 3'd3; #1;
    n_vec++;
    if (dbg_data !== 16'h3333 || flags !== 4'b0010 || n_wb != w0) begin
      n_err++;
      $display("FAIL nop_no_effect: got r3=%h flags=%b wb_cycles=%0d expected 3333 0010 0", dbg_data, flags, n_wb - w0);
    end
    ext_load(3'd0, 16'h0000);
    ext_we = 1'b1; ext_addr = 3'd1; ext_data = 16'h00AA;
    mreg[1] = 16'h00AA;
    issue(OP_OR, 3'd2, 3'd1, 3'd0, 1'b0, acc);
    settle();
    dbg_addr = 3'd2; #1;
    n_vec++;
    if (dbg_data !== 16'h00AA || flags !== 4'b0000) begin
      n_err++; $display("FAIL same_edge_load: got r2=%h flags=%b expected 00aa 0000", dbg_data, flags);
    end
    ext_we = 1'b1; ext_addr = 3'd6; ext_data = 16'hDEAD;
    @(posedge clk); #1;
    ext_we = 1'b0;
    issue(OP_OR, 3'd5, 3'd0, 3'd0, 1'b0, acc);
    ext_we = 1'b1; ext_addr = 3'd6; ext_data = 16'hBAD0;
    settle();
    ext_we = 1'b0;
    mreg[6] = 16'hDEAD;
    dbg_addr = 3'd6; #1;
    n_vec++;
    if (dbg_data !== 16'hDEAD) begin
      n_err++; $display("FAIL ext_we_busy_ignored: got r6=%h expected dead", dbg_data);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_mov();
    test_back_to_back();
    test_reset_exec();
    test_nop_same_edge();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d pending writebacks expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
